collision_monitor: RTL and testbench

//  Producer side of the death/respawn handshake: watches the per-pixel overlap of player and

---
 rtl/collision_pkg.sv | 18 +
 rtl/frame_overlap_counter.sv | 38 +++
 rtl/collision_monitor.sv | 138 +++++++++++++
 tb/tb_collision_monitor.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared types and constants for the collision monitor (state encoding, death counter sizing).
package collision_pkg;

  typedef enum logic [1:0] {
    CM_ARMED    = 2'd0,
    CM_HIT_PEND = 2'd1,
    CM_GRACE    = 2'd2
  } cm_state_t;

  localparam int unsigned DEATH_CNT_W = 8;
  localparam logic [DEATH_CNT_W-1:0] DEATH_CNT_MAX = 8'hFF;
  localparam int unsigned STREAK_W = 4;

  function automatic logic [DEATH_CNT_W-1:0] death_cnt_inc(input logic [DEATH_CNT_W-1:0] v);
    return (v == DEATH_CNT_MAX) ? v : v + DEATH_CNT_W'(1);
  endfunction

endpackage

// File: rtl/frame_overlap_counter.sv
// Per-frame saturating overlap pixel counter; emits a hit pulse on frame_start when the
// frame just closed reached HIT_THRESH overlap pixels.
module frame_overlap_counter #(
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned HIT_THRESH = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_start,
  input  logic pix_overlap,
  input  logic clr,
  output logic frame_hit_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // An overlap pixel coincident with frame_start belongs to the new frame.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (frame_start) begin
      cnt_d = pix_overlap ? CNT_W'(1) : '0;
    end else if (pix_overlap && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign frame_hit_c = frame_start && (cnt_q >= CNT_W'(HIT_THRESH));

endmodule

// File: rtl/collision_monitor.sv
// Player/obstacle collision detector with per-frame debounce and dead/die_reset handshake.
// Optional post-death invulnerability window enabled by COLLISION_GRACE_EN.
module collision_monitor
  import collision_pkg::*;
#(
  parameter int unsigned CNT_W           = 10,
  parameter int unsigned HIT_THRESH      = 4,
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned GRACE_FRAMES    = 60
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_start,
  input  logic                   pixel_valid,
  input  logic                   is_player,
  input  logic                   is_obstacle,
  input  logic                   die_reset,
  output logic                   dead,
  output logic [DEATH_CNT_W-1:0] death_count,
  output logic                   invuln
);

  cm_state_t              state_q, state_d;
  logic [STREAK_W-1:0]    streak_q, streak_d;
  logic [DEATH_CNT_W-1:0] deaths_q, deaths_d;
  logic                   dead_q, dead_d;
  logic                   frame_hit_c;
  logic                   pix_overlap_c;
  logic                   ovl_clr_c;

  // Overlap only accumulates while armed; die_reset in ARMED restarts the frame count.
  assign pix_overlap_c = pixel_valid && is_player && is_obstacle && (state_q == CM_ARMED);
  assign ovl_clr_c     = (state_q != CM_ARMED) || die_reset;

  frame_overlap_counter #(
    .CNT_W      (CNT_W),
    .HIT_THRESH (HIT_THRESH)
  ) u_overlap (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .pix_overlap (pix_overlap_c),
    .clr         (ovl_clr_c),
    .frame_hit_c (frame_hit_c)
  );

`ifdef COLLISION_GRACE_EN
  localparam int unsigned GRACE_W = (GRACE_FRAMES < 2) ? 1 : $clog2(GRACE_FRAMES + 1);
  logic [GRACE_W-1:0] grace_q, grace_d;
  logic               invuln_q, invuln_d;
`else
  logic unused_grace;
  assign unused_grace = ^GRACE_FRAMES;
`endif

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    deaths_d = deaths_q;
`ifdef COLLISION_GRACE_EN
    grace_d  = grace_q;
`endif
    case (state_q)
      CM_ARMED: begin
        // A closing debounce frame wins over a simultaneous die_reset.
        if (frame_hit_c && ((streak_q + STREAK_W'(1)) == STREAK_W'(DEBOUNCE_FRAMES))) begin
          state_d  = CM_HIT_PEND;
          streak_d = '0;
        end else if (die_reset) begin
          streak_d = '0;
        end else if (frame_start) begin
          streak_d = frame_hit_c ? streak_q + STREAK_W'(1) : '0;
        end
      end
      CM_HIT_PEND: begin
        if (die_reset) begin
          deaths_d = death_cnt_inc(deaths_q);
`ifdef COLLISION_GRACE_EN
          state_d  = CM_GRACE;
          grace_d  = GRACE_W'(GRACE_FRAMES);
`else
          state_d  = CM_ARMED;
`endif
        end
      end
      CM_GRACE: begin
`ifdef COLLISION_GRACE_EN
        if (frame_start) begin
          if (grace_q <= GRACE_W'(1)) begin
            state_d = CM_ARMED;
            grace_d = '0;
          end else begin
            grace_d = grace_q - GRACE_W'(1);
          end
        end
`else
        state_d = CM_ARMED;
`endif
      end
      default: state_d = CM_ARMED;
    endcase
    dead_d = (state_d == CM_HIT_PEND);
`ifdef COLLISION_GRACE_EN
    invuln_d = (state_d == CM_GRACE);
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= CM_ARMED;
      streak_q <= '0;
      deaths_q <= '0;
      dead_q   <= 1'b0;
`ifdef COLLISION_GRACE_EN
      grace_q  <= '0;
      invuln_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      deaths_q <= deaths_d;
      dead_q   <= dead_d;
`ifdef COLLISION_GRACE_EN
      grace_q  <= grace_d;
      invuln_q <= invuln_d;
`endif
    end
  end

  assign dead        = dead_q;
  assign death_count = deaths_q;
`ifdef COLLISION_GRACE_EN
  assign invuln      = invuln_q;
`else
  assign invuln      = 1'b0;
`endif

endmodule

// File: tb/tb_collision_monitor.sv
// Scoreboard bench for collision_monitor: default instance plus a fast instance
// (HIT_THRESH=1, DEBOUNCE_FRAMES=1, GRACE_FRAMES=1) for same-cycle and saturation cases.
module tb_collision_monitor;

`ifdef COLLISION_GRACE_EN
  localparam logic G = 1'b1;
`else
  localparam logic G = 1'b0;
`endif

  typedef struct {
    logic       dead;
    logic [7:0] cnt;
    logic       inv;
  } exp_t;

  logic       Clk, Reset;
  logic       frame_start, pixel_valid, is_player, is_obstacle, die_reset;
  logic       dead, invuln, dead1, invuln1;
  logic [7:0] death_count, death_count1;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  collision_monitor dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .is_player(is_player), .is_obstacle(is_obstacle), .die_reset(die_reset),
    .dead(dead), .death_count(death_count), .invuln(invuln)
  );

  collision_monitor #(.HIT_THRESH(1), .DEBOUNCE_FRAMES(1), .GRACE_FRAMES(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .is_player(is_player), .is_obstacle(is_obstacle), .die_reset(die_reset),
    .dead(dead1), .death_count(death_count1), .invuln(invuln1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic clk1(input logic fs, input logic pv, input logic ob, input logic dr);
    frame_start = fs; pixel_valid = pv; is_player = 1'b1; is_obstacle = ob; die_reset = dr;
    @(posedge Clk); #1;
    frame_start = 1'b0; pixel_valid = 1'b0; is_obstacle = 1'b0; die_reset = 1'b0;
  endtask

  // n overlap pixels, then off-screen overlap (must not count), then the closing frame_start
  task automatic drive_frame(input int n, input logic dr_at_fs);
    for (int i = 0; i < n; i++) clk1(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) clk1(1'b0, 1'b0, 1'b1, 1'b0);
    clk1(1'b1, 1'b1, 1'b0, dr_at_fs);
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    frame_start = 1'b0; pixel_valid = 1'b0; is_player = 1'b0; is_obstacle = 1'b0; die_reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    sb.push_back('{1'b0, 8'd0, 1'b0});
    sb.push_back('{1'b0, 8'd0, 1'b0});
    e = sb.pop_front(); n_tests++;
    if ({dead, death_count, invuln} !== {e.dead, e.cnt, e.inv}) begin
      n_fail++; $display("FAIL reset: got dead=%b cnt=%0d inv=%b want dead=%b cnt=%0d inv=%b",
                         dead, death_count, invuln, e.dead, e.cnt, e.inv);
    end
    e = sb.pop_front(); n_tests++;
    if ({dead1, death_count1, invuln1} !== {e.dead, e.cnt, e.inv}) begin
      n_fail++; $display("FAIL reset_fast: got dead=%b cnt=%0d inv=%b want dead=%b cnt=%0d inv=%b",
                         dead1, death_count1, invuln1, e.dead, e.cnt, e.inv);
    end
  endtask

  task automatic test_debounce();
    int   ov[4] = '{0, 5, 5, 5};
    logic ed[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{ed[i], 8'd0, 1'b0});
      drive_frame(ov[i], 1'b0);
      e = sb.pop_front(); n_tests++;
      if ({dead, death_count, invuln} !== {e.dead, e.cnt, e.inv}) begin
        n_fail++; $display("FAIL debounce[%0d]: got dead=%b cnt=%0d inv=%b want dead=%b cnt=%0d inv=%b",
                           i, dead, death_count, invuln, e.dead, e.cnt, e.inv);
      end
    end
  endtask

  task automatic test_streak_clear();
    int   ov[5] = '{0, 5, 3, 4, 4};
    logic ed[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{ed[i], 8'd0, 1'b0});
      drive_frame(ov[i], 1'b0);
      e = sb.pop_front(); n_tests++;
      if ({dead, death_count, invuln} !== {e.dead, e.cnt, e.inv}) begin
        n_fail++; $display("FAIL streak_clear[%0d]: got dead=%b cnt=%0d inv=%b want dead=%b cnt=%0d inv=%b",
                           i, dead, death_count, invuln, e.dead, e.cnt, e.inv);
      end
    end
  endtask

  // Entered with dead=1 and death_count=0
  task automatic test_ack_grace();
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{1'b0, 8'd1, G});
      clk1(1'b0, 1'b0, 1'b0, 1'b1);
      e = sb.pop_front(); n_tests++;
      if ({dead, death_count, invuln} !== {e.dead, e.cnt, e.inv}) begin
        n_fail++; $display("FAIL ack[%0d]: got dead=%b cnt=%0d inv=%b want dead=%b cnt=%0d inv=%b",
                           i, dead, death_count, invuln, e.dead, e.cnt, e.inv);
      end
    end
    if (G) begin
      for (int i = 1; i <= 60; i++) begin
        sb.push_back('{1'b0, 8'd1, (i < 60)});
        drive_frame(5, 1'b0);
        e = sb.pop_front(); n_tests++;
        if ({dead, death_count, invuln} !== {e.dead, e.cnt, e.inv}) begin
          n_fail++; $display("FAIL grace[%0d]: got dead=%b cnt=%0d inv=%b want dead=%b cnt=%0d inv=%b",
                             i, dead, death_count, invuln, e.dead, e.cnt, e.inv);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{(i == 1), 8'd1, 1'b0});
      drive_frame(5, 1'b0);
      e = sb.pop_front(); n_tests++;
      if ({dead, death_count, invuln} !== {e.dead, e.cnt, e.inv}) begin
        n_fail++; $display("FAIL rearm[%0d]: got dead=%b cnt=%0d inv=%b want dead=%b cnt=%0d inv=%b",
                           i, dead, death_count, invuln, e.dead, e.cnt, e.inv);
      end
    end
  endtask

  task automatic test_ack_race();
    apply_reset();
    drive_frame(0, 1'b0);
    drive_frame(5, 1'b0);
    sb.push_back('{1'b1, 8'd0, 1'b0});
    sb.push_back('{1'b1, 8'd0, 1'b0});
    sb.push_back('{1'b0, 8'd1, G});
    drive_frame(5, 1'b1);
    e = sb.pop_front(); n_tests++;
    if ({dead, death_count, invuln} !== {e.dead, e.cnt, e.inv}) begin
      n_fail++; $display("FAIL race_rise: got dead=%b cnt=%0d inv=%b want dead=%b cnt=%0d inv=%b",
                         dead, death_count, invuln, e.dead, e.cnt, e.inv);
    end
    repeat (2) clk1(1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); n_tests++;
    if ({dead, death_count, invuln} !== {e.dead, e.cnt, e.inv}) begin
      n_fail++; $display("FAIL race_hold: got dead=%b cnt=%0d inv=%b want dead=%b cnt=%0d inv=%b",
                         dead, death_count, invuln, e.dead, e.cnt, e.inv);
    end
    clk1(1'b0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); n_tests++;
    if ({dead, death_count, invuln} !== {e.dead, e.cnt, e.inv}) begin
      n_fail++; $display("FAIL race_ack: got dead=%b cnt=%0d inv=%b want dead=%b cnt=%0d inv=%b",
                         dead, death_count, invuln, e.dead, e.cnt, e.inv);
    end
  endtask

  task automatic test_same_cycle_pixel();
    logic fs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic ob[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic ed[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{ed[i], 8'd0, 1'b0});
      clk1(fs[i], 1'b1, ob[i], 1'b0);
      e = sb.pop_front(); n_tests++;
      if (dead1 !== e.dead) begin
        n_fail++; $display("FAIL same_cycle[%0d]: got dead=%b want dead=%b", i, dead1, e.dead);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive_frame(0, 1'b0); drive_frame(5, 1'b0); drive_frame(5, 1'b0);
    clk1(1'b0, 1'b0, 1'b0, 1'b1);
    if (!G) begin
      drive_frame(5, 1'b0); drive_frame(5, 1'b0);
    end
    sb.push_back('{!G, 8'd1, G});
    sb.push_back('{1'b0, 8'd0, 1'b0});
    e = sb.pop_front(); n_tests++;
    if ({dead, death_count, invuln} !== {e.dead, e.cnt, e.inv}) begin
      n_fail++; $display("FAIL pre_async: got dead=%b cnt=%0d inv=%b want dead=%b cnt=%0d inv=%b",
                         dead, death_count, invuln, e.dead, e.cnt, e.inv);
    end
    Reset = 1'b1;
    #2;
    e = sb.pop_front(); n_tests++;
    if ({dead, death_count, invuln} !== {e.dead, e.cnt, e.inv}) begin
      n_fail++; $display("FAIL async_reset: got dead=%b cnt=%0d inv=%b want dead=%b cnt=%0d inv=%b",
                         dead, death_count, invuln, e.dead, e.cnt, e.inv);
    end
    @(posedge Clk); #1 Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{(i == 2), 8'd0, 1'b0});
      drive_frame((i == 0) ? 0 : 5, 1'b0);
      e = sb.pop_front(); n_tests++;
      if ({dead, death_count, invuln} !== {e.dead, e.cnt, e.inv}) begin
        n_fail++; $display("FAIL resume[%0d]: got dead=%b cnt=%0d inv=%b want dead=%b cnt=%0d inv=%b",
                           i, dead, death_count, invuln, e.dead, e.cnt, e.inv);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 1; k <= 256; k++) begin
      clk1(1'b0, 1'b1, 1'b1, 1'b0);
      clk1(1'b1, 1'b1, 1'b0, 1'b0);
      if (k == 1 || k == 128) begin
        sb.push_back('{1'b1, 8'(k - 1), 1'b0});
        e = sb.pop_front(); n_tests++;
        if ({dead1, death_count1, invuln1} !== {e.dead, e.cnt, e.inv}) begin
          n_fail++; $display("FAIL b2b_dead[%0d]: got dead=%b cnt=%0d inv=%b want dead=%b cnt=%0d inv=%b",
                             k, dead1, death_count1, invuln1, e.dead, e.cnt, e.inv);
        end
      end
      clk1(1'b0, 1'b0, 1'b0, 1'b1);
      if (k == 1 || k == 254 || k == 255 || k == 256) begin
        sb.push_back('{1'b0, (k > 255) ? 8'd255 : 8'(k), G});
        e = sb.pop_front(); n_tests++;
        if ({dead1, death_count1, invuln1} !== {e.dead, e.cnt, e.inv}) begin
          n_fail++; $display("FAIL b2b_ack[%0d]: got dead=%b cnt=%0d inv=%b want dead=%b cnt=%0d inv=%b",
                             k, dead1, death_count1, invuln1, e.dead, e.cnt, e.inv);
        end
      end
      clk1(1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_streak_clear();
    test_ack_grace();
    test_ack_race();
    test_same_cycle_pixel();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
